// File: rtl/alu_commit_pkg.sv
// Shared definitions for the ALU commit stage: bundle layout, control-type and
// trap-cause codes, load size codes, FSM encoding and store-lane replication.
package alu_commit_pkg;

   localparam logic [1:0] CT_MEM  = 2'd0;
   localparam logic [1:0] CT_SYS  = 2'd1;
   localparam logic [1:0] CT_REG  = 2'd2;
   localparam logic [1:0] CT_TRAP = 2'd3;

   localparam logic [5:0] CAUSE_ILLEGAL        = 6'd2;
   localparam logic [5:0] CAUSE_LOAD_MISALIGN  = 6'd4;
   localparam logic [5:0] CAUSE_LOAD_FAULT     = 6'd5;
   localparam logic [5:0] CAUSE_STORE_MISALIGN = 6'd6;
   localparam logic [5:0] CAUSE_STORE_FAULT    = 6'd7;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   localparam int BUNDLE_W      = 74;
   localparam int BIT_VALID     = 73;
   localparam int BIT_CTYPE_LO  = 71;
   localparam int BIT_RESULT_LO = 39;
   localparam int BIT_EADDR_LO  = 7;
   localparam int BIT_CAUSE_LO  = 1;
   localparam int BIT_REDIRECT  = 0;

   typedef struct packed {
      logic        valid;
      logic [1:0]  ctype;
      logic [31:0] result;
      logic [31:0] eaddr;
      logic [5:0]  cause;
      logic        redirect;
   } bundle_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } state_t;

   // Store data copied into every byte lane the access size could occupy.
   function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] data);
      logic [31:0] out;
      case (size)
         2'd0:    out = {4{data[7:0]}};
         2'd1:    out = {2{data[15:0]}};
         default: out = data;
      endcase
      return out;
   endfunction

endpackage

// File: rtl/alu_commit_unit_if.sv
// Execute-stage bundle input, data-bus request/response and retire outputs of
// the ALU commit unit; master is the unit, slave is its environment.
interface alu_commit_unit_if;

   logic        in_valid;
   logic        in_ready;
   logic [73:0] in_bundle;
   logic [4:0]  in_rd;
   logic [2:0]  in_funct3;
   logic [1:0]  in_memaccess;
   logic [31:0] in_store_data;

   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [31:0] dmem_req_addr;
   logic        dmem_req_wr;
   logic [1:0]  dmem_req_size;
   logic [31:0] dmem_req_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_rdata;
   logic        dmem_rsp_err;

   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        trap_valid;
   logic [5:0]  trap_cause;
   logic [31:0] trap_tval;
   logic        sys_valid;

   modport master (
      input  in_valid, in_bundle, in_rd, in_funct3, in_memaccess, in_store_data,
      input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_err,
      output in_ready,
      output dmem_req_valid, dmem_req_addr, dmem_req_wr, dmem_req_size, dmem_req_wdata,
      output wb_valid, wb_rd, wb_data, redirect_valid, redirect_pc,
      output trap_valid, trap_cause, trap_tval, sys_valid
   );

   modport slave (
      output in_valid, in_bundle, in_rd, in_funct3, in_memaccess, in_store_data,
      output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_err,
      input  in_ready,
      input  dmem_req_valid, dmem_req_addr, dmem_req_wr, dmem_req_size, dmem_req_wdata,
      input  wb_valid, wb_rd, wb_data, redirect_valid, redirect_pc,
      input  trap_valid, trap_cause, trap_tval, sys_valid
   );

endinterface

// File: rtl/load_align.sv
// Moves the addressed byte/half/word of a bus word down to bit 0 and extends it
// according to the load funct3; purely combinational.
module load_align
   import alu_commit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted_s;

   // Lane select then sign/zero extension; unknown funct3 returns the shifted word.
   always_comb begin
      shifted_s = rdata >> {offset, 3'b000};
      data      = shifted_s;
      case (funct3)
         F3_LB:   data = {{24{shifted_s[7]}}, shifted_s[7:0]};
         F3_LH:   data = {{16{shifted_s[15]}}, shifted_s[15:0]};
         F3_LW:   data = shifted_s;
         F3_LBU:  data = {24'h000000, shifted_s[7:0]};
         F3_LHU:  data = {16'h0000, shifted_s[15:0]};
         default: data = shifted_s;
      endcase
   end

endmodule

// File: rtl/alu_commit_unit.sv
// Retires fn_alu result bundles: register writeback, fetch redirect, traps,
// system hand-off, and single outstanding data-bus loads/stores.
module alu_commit_unit
   import alu_commit_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int RSP_TIMEOUT = 255
)(
   input  logic              CLK,
   input  logic              RST_N,
   alu_commit_unit_if.master bus
);

   localparam logic [15:0] TIMEOUT_L  = 16'(RSP_TIMEOUT);
   localparam bit          TIMEOUT_EN = (RSP_TIMEOUT != 0);

   state_t            state_r;
   logic              in_ready_r;
   logic              req_valid_r;
   logic              req_wr_r;
   logic [31:0]       req_wdata_r;
   logic [XLEN-1:0]   eaddr_r;
   logic [4:0]        rd_r;
   logic [2:0]        funct3_r;
   logic [15:0]       cnt_r;
   logic              wb_valid_r;
   logic [4:0]        wb_rd_r;
   logic [31:0]       wb_data_r;
   logic              redirect_valid_r;
   logic [31:0]       redirect_pc_r;
   logic              trap_valid_r;
   logic [5:0]        trap_cause_r;
   logic [31:0]       trap_tval_r;
   logic              sys_valid_r;

   bundle_t           bundle_s;
   logic [31:0]       load_data_s;

   assign bundle_s = bundle_t'(bus.in_bundle);

   load_align u_load_align (
      .rdata  (bus.dmem_rsp_rdata),
      .offset (eaddr_r[1:0]),
      .funct3 (funct3_r),
      .data   (load_data_s)
   );

   // Commit FSM; every output is a register so pulses are exactly one cycle wide.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_r          <= ST_IDLE;
         in_ready_r       <= 1'b0;
         req_valid_r      <= 1'b0;
         req_wr_r         <= 1'b0;
         req_wdata_r      <= 32'h0000_0000;
         eaddr_r          <= '0;
         rd_r             <= 5'd0;
         funct3_r         <= 3'd0;
         cnt_r            <= 16'd0;
         wb_valid_r       <= 1'b0;
         wb_rd_r          <= 5'd0;
         wb_data_r        <= 32'h0000_0000;
         redirect_valid_r <= 1'b0;
         redirect_pc_r    <= 32'h0000_0000;
         trap_valid_r     <= 1'b0;
         trap_cause_r     <= 6'd0;
         trap_tval_r      <= 32'h0000_0000;
         sys_valid_r      <= 1'b0;
      end else begin
         wb_valid_r       <= 1'b0;
         redirect_valid_r <= 1'b0;
         trap_valid_r     <= 1'b0;
         sys_valid_r      <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               in_ready_r <= 1'b1;
               // Bundles with bit 73 clear are consumed silently.
               if (bus.in_valid && in_ready_r && bundle_s.valid) begin
                  case (bundle_s.ctype)
                     CT_TRAP: begin
                        trap_valid_r <= 1'b1;
                        trap_cause_r <= bundle_s.cause;
                        trap_tval_r  <= bundle_s.eaddr;
                     end
                     CT_REG: begin
                        wb_valid_r <= (bus.in_rd != 5'd0);
                        wb_rd_r    <= bus.in_rd;
                        wb_data_r  <= bundle_s.result;
                        if (bundle_s.redirect) begin
                           redirect_valid_r <= 1'b1;
                           redirect_pc_r    <= bundle_s.eaddr;
                        end
                     end
                     CT_SYS: begin
                        sys_valid_r <= 1'b1;
                        wb_rd_r     <= bus.in_rd;
                        wb_data_r   <= bundle_s.result;
                     end
                     default: begin
                        if (bus.in_memaccess[1]) begin
                           trap_valid_r <= 1'b1;
                           trap_cause_r <= CAUSE_ILLEGAL;
                           trap_tval_r  <= bundle_s.eaddr;
                        end else begin
                           eaddr_r     <= bundle_s.eaddr;
                           rd_r        <= bus.in_rd;
                           funct3_r    <= bus.in_funct3;
                           req_wr_r    <= bus.in_memaccess[0];
                           req_wdata_r <= replicate_wdata(bus.in_funct3[1:0], bus.in_store_data);
                           req_valid_r <= 1'b1;
                           in_ready_r  <= 1'b0;
                           state_r     <= ST_REQ;
                        end
                     end
                  endcase
               end
            end
            ST_REQ: begin
               if (bus.dmem_req_ready) begin
                  req_valid_r <= 1'b0;
                  cnt_r       <= 16'd0;
                  state_r     <= ST_RSP;
               end
            end
            ST_RSP: begin
               // A response in the same cycle as the timeout still wins.
               if (bus.dmem_rsp_valid) begin
                  if (bus.dmem_rsp_err) begin
                     trap_valid_r <= 1'b1;
                     trap_cause_r <= req_wr_r ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                     trap_tval_r  <= eaddr_r;
                  end else if (!req_wr_r) begin
                     wb_valid_r <= (rd_r != 5'd0);
                     wb_rd_r    <= rd_r;
                     wb_data_r  <= load_data_s;
                  end
                  in_ready_r <= 1'b1;
                  state_r    <= ST_IDLE;
               end else if (TIMEOUT_EN && (cnt_r == TIMEOUT_L)) begin
                  trap_valid_r <= 1'b1;
                  trap_cause_r <= req_wr_r ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                  trap_tval_r  <= eaddr_r;
                  in_ready_r   <= 1'b1;
                  state_r      <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            default: begin
               in_ready_r  <= 1'b0;
               req_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready       = in_ready_r;
   assign bus.dmem_req_valid = req_valid_r;
   assign bus.dmem_req_addr  = {eaddr_r[XLEN-1:2], 2'b00};
   assign bus.dmem_req_wr    = req_wr_r;
   assign bus.dmem_req_size  = funct3_r[1:0];
   assign bus.dmem_req_wdata = req_wdata_r;
   assign bus.wb_valid       = wb_valid_r;
   assign bus.wb_rd          = wb_rd_r;
   assign bus.wb_data        = wb_data_r;
   assign bus.redirect_valid = redirect_valid_r;
   assign bus.redirect_pc    = redirect_pc_r;
   assign bus.trap_valid     = trap_valid_r;
   assign bus.trap_cause     = trap_cause_r;
   assign bus.trap_tval      = trap_tval_r;
   assign bus.sys_valid      = sys_valid_r;

endmodule
